// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the integer execute stage: widths, ALU opcodes,
// and the operand-forwarding match helper.
package alu_exec_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned SHAMT_W   = 5;

  // ALU opcodes as produced by decode; unlisted encodings retire with result 0.
  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } alu_op_e;

  // True when a source index can take a forwarded value; x0 never matches.
  function automatic logic fwd_hit(input logic [REG_IDX_W-1:0] src_idx,
                                   input logic [REG_IDX_W-1:0] dst_idx,
                                   input logic                 dst_valid);
    return dst_valid && (src_idx == dst_idx) && (src_idx != '0);
  endfunction

endpackage

// File: rtl/alu_exec_stage_shifter.sv
// Combinational 32-bit barrel shifter: logical left, logical right or
// arithmetic right, selected by lsl/signd.
module alu_exec_stage_shifter
  import alu_exec_stage_pkg::*;
(
  input  logic [XLEN-1:0]    data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               lsl,
  input  logic               signd,
  output logic [XLEN-1:0]    result
);

  logic [XLEN-1:0] stage [SHAMT_W+1];
  logic [XLEN-1:0] rev_in;
  logic [XLEN-1:0] rev_out;
  logic            fill;

  // Left shifts reuse the right-shift network by bit-reversing in and out.
  always_comb begin
    rev_in = '0;
    for (int i = 0; i < int'(XLEN); i++) begin
      rev_in[i] = data[XLEN-1-i];
    end
  end

  // Fill bit is the sign only for arithmetic right shifts.
  assign fill = signd && !lsl && data[XLEN-1];

  // Five log stages, each shifting right by 2^k when shamt[k] is set.
  always_comb begin
    stage[0] = lsl ? rev_in : data;
    for (int k = 0; k < int'(SHAMT_W); k++) begin
      if (shamt[k]) begin
        stage[k+1] = (stage[k] >> (1 << k)) |
                     ({XLEN{fill}} & ~({XLEN{1'b1}} >> (1 << k)));
      end else begin
        stage[k+1] = stage[k];
      end
    end
  end

  // Undo the reversal for left shifts.
  always_comb begin
    rev_out = '0;
    for (int i = 0; i < int'(XLEN); i++) begin
      rev_out[i] = stage[SHAMT_W][XLEN-1-i];
    end
    result = lsl ? rev_out : stage[SHAMT_W];
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Integer execute stage: accepts one decoded ALU op per cycle, resolves
// operands through a one-deep bypass, computes the result and holds it in a
// valid/ready output register toward writeback.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_op,
  input  logic [XLEN-1:0]      in_rs1_val,
  input  logic [XLEN-1:0]      in_rs2_val,
  input  logic [REG_IDX_W-1:0] in_rs1_idx,
  input  logic [REG_IDX_W-1:0] in_rs2_idx,
  input  logic [XLEN-1:0]      in_imm,
  input  logic                 in_use_imm,
  input  logic [REG_IDX_W-1:0] in_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic [XLEN-1:0]      out_result
);

  logic                 accept;
  logic                 xfer;
  logic [XLEN-1:0]      op_a;
  logic [XLEN-1:0]      rs2_fwd;
  logic [XLEN-1:0]      op_b;
  logic [XLEN-1:0]      alu_result;
  logic [XLEN-1:0]      shift_result;
  logic                 shift_lsl;
  logic                 shift_signd;
  logic                 byp_valid;
  logic [REG_IDX_W-1:0] byp_rd;
  logic [XLEN-1:0]      byp_value;

  // Ready whenever the output slot is free or draining; flush blocks intake.
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  // A flush cancels the writeback transfer even if out_ready is high.
  assign xfer     = out_valid && out_ready && !flush;

  // Operand select: live output register beats the bypass register.
  always_comb begin
    op_a = in_rs1_val;
    if (fwd_hit(in_rs1_idx, byp_rd, byp_valid)) begin
      op_a = byp_value;
    end
    if (fwd_hit(in_rs1_idx, out_rd, out_valid)) begin
      op_a = out_result;
    end

    rs2_fwd = in_rs2_val;
    if (fwd_hit(in_rs2_idx, byp_rd, byp_valid)) begin
      rs2_fwd = byp_value;
    end
    if (fwd_hit(in_rs2_idx, out_rd, out_valid)) begin
      rs2_fwd = out_result;
    end

    op_b = in_use_imm ? in_imm : rs2_fwd;
  end

  // Shifter direction and sign controls decoded from the opcode.
  always_comb begin
    shift_lsl   = 1'b0;
    shift_signd = 1'b0;
    case (alu_op_e'(in_op))
      OP_SLL:  shift_lsl   = 1'b1;
      OP_SRA:  shift_signd = 1'b1;
      default: ;
    endcase
  end

  alu_exec_stage_shifter u_shifter (
    .data   (op_a),
    .shamt  (op_b[SHAMT_W-1:0]),
    .lsl    (shift_lsl),
    .signd  (shift_signd),
    .result (shift_result)
  );

  // Result mux; unknown encodings yield zero but still retire.
  always_comb begin
    alu_result = '0;
    case (alu_op_e'(in_op))
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_SLT:  alu_result = XLEN'($signed(op_a) < $signed(op_b));
      OP_SLTU: alu_result = XLEN'(op_a < op_b);
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_SLL,
      OP_SRL,
      OP_SRA:  alu_result = shift_result;
      default: alu_result = '0;
    endcase
  end

  // Output register: loads on accept, empties on transfer or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_rd     <= '0;
      out_result <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        out_rd     <= in_rd;
        out_result <= alu_result;
      end
    end
  end

  // Bypass register captures each retired non-x0 result.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_valid <= 1'b0;
      byp_rd    <= '0;
      byp_value <= '0;
    end else if (flush) begin
      byp_valid <= 1'b0;
    end else if (xfer && (out_rd != '0)) begin
      byp_valid <= 1'b1;
      byp_rd    <= out_rd;
      byp_value <= out_result;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic [4:0]  in_rs1_idx;
  logic [4:0]  in_rs2_idx;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_result;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: the op sitting at the stage output, and the most
  // recently retired non-x0 result since the last flush/reset.
  logic        m_valid;
  logic [4:0]  m_rd;
  logic [31:0] m_res;
  logic        r_valid;
  logic [4:0]  r_rd;
  logic [31:0] r_val;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1_val (in_rs1_val),
    .in_rs2_val (in_rs2_val),
    .in_rs1_idx (in_rs1_idx),
    .in_rs2_idx (in_rs2_idx),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rd     (out_rd),
    .out_result (out_result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Architectural ALU semantics computed with wide signed/unsigned arithmetic.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    int     sh = int'(b % 32);
    case (op)
      4'd0:    return 32'(ua + ub);
      4'd1:    return 32'(ua - ub);
      4'd2:    return 32'(ua * (64'd1 << sh));
      4'd3:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:    return (ua < ub) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return 32'(ua / (64'd1 << sh));
      4'd7:    return 32'(sa >>> sh);
      4'd8:    return a | b;
      4'd9:    return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // Value a source register should read: newest producer not yet in the RF.
  function automatic logic [31:0] src_val(input logic [4:0] idx, input logic [31:0] rf_val);
    if (idx == 5'd0) return rf_val;
    if (m_valid && m_rd == idx) return m_res;
    if (r_valid && r_rd == idx) return r_val;
    return rf_val;
  endfunction

  // Compare current outputs with the model, then advance the model over one edge.
  task automatic step();
    logic        rdy;
    logic [31:0] a;
    logic [31:0] b;
    #1;
    rdy = !flush && (!m_valid || out_ready);
    check("in_ready",   32'(in_ready),  32'(rdy));
    check("out_valid",  32'(out_valid), 32'(m_valid));
    check("out_rd",     32'(out_rd),    32'(m_rd));
    check("out_result", out_result,     m_res);
    if (rst) begin
      m_valid = 1'b0; m_rd = '0; m_res = '0;
      r_valid = 1'b0; r_rd = '0; r_val = '0;
    end else if (flush) begin
      m_valid = 1'b0;
      r_valid = 1'b0;
    end else begin
      a = src_val(in_rs1_idx, in_rs1_val);
      b = in_use_imm ? in_imm : src_val(in_rs2_idx, in_rs2_val);
      if (m_valid && out_ready && m_rd != 5'd0) begin
        r_valid = 1'b1; r_rd = m_rd; r_val = m_res;
      end
      if (in_valid && rdy) begin
        m_valid = 1'b1; m_rd = in_rd; m_res = ref_alu(in_op, a, b);
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] r1v,
                       input logic [31:0] r2v, input logic [4:0] r1i, input logic [4:0] r2i,
                       input logic [31:0] imm, input logic ui, input logic [4:0] rd,
                       input logic ordy, input logic fl);
    in_valid = v; in_op = op; in_rs1_val = r1v; in_rs2_val = r2v;
    in_rs1_idx = r1i; in_rs2_idx = r2i; in_imm = imm; in_use_imm = ui;
    in_rd = rd; out_ready = ordy; flush = fl;
    step();
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
  endtask

  initial begin
    m_valid = 1'b0; m_rd = '0; m_res = '0;
    r_valid = 1'b0; r_rd = '0; r_val = '0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_rs1_val = '0; in_rs2_val = '0; in_rs1_idx = '0; in_rs2_idx = '0;
    in_imm = '0; in_use_imm = 1'b0; in_rd = '0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset then idle
    idle();
    idle();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Shifts, including shamt taken from the low five bits only
    drive(1'b1, OP_SRA, 32'h80000010, 32'd0, 5'd10, 5'd11, 32'd4, 1'b1, 5'd1, 1'b1, 1'b0);
    check("sra", out_result, 32'hF8000001);
    drive(1'b1, OP_SRL, 32'h80000010, 32'd0, 5'd10, 5'd11, 32'd4, 1'b1, 5'd2, 1'b1, 1'b0);
    check("srl", out_result, 32'h08000001);
    drive(1'b1, OP_SLL, 32'h00000001, 32'h23, 5'd10, 5'd11, 32'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    check("sll", out_result, 32'h00000008);
    idle();

    // Back-pressure: first op captured, later ones stalled
    drive(1'b1, OP_ADD, 32'd5, 32'd6, 5'd20, 5'd21, 32'd0, 1'b0, 5'd12, 1'b0, 1'b0);
    check("bp_first", out_result, 32'd11);
    drive(1'b1, OP_ADD, 32'd100, 32'd1, 5'd20, 5'd21, 32'd0, 1'b0, 5'd13, 1'b0, 1'b0);
    check("bp_hold1", out_result, 32'd11);
    drive(1'b1, OP_ADD, 32'd100, 32'd1, 5'd20, 5'd21, 32'd0, 1'b0, 5'd13, 1'b0, 1'b0);
    check("bp_hold2", out_result, 32'd11);
    check("bp_stall_rdy", 32'(in_ready), 32'd0);
    drive(1'b1, OP_ADD, 32'd100, 32'd1, 5'd20, 5'd21, 32'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    check("bp_release", out_result, 32'd101);
    check("bp_release_v", 32'(out_valid), 32'd1);
    idle();

    // Bypass chain, and x0 never forwarded
    drive(1'b1, OP_ADD, 32'd3, 32'd4, 5'd20, 5'd21, 32'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    drive(1'b1, OP_ADD, 32'd0, 32'd0, 5'd5, 5'd21, 32'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    check("byp_chain", out_result, 32'd8);
    idle();
    drive(1'b1, OP_ADD, 32'd0, 32'd0, 5'd6, 5'd21, 32'd2, 1'b1, 5'd7, 1'b1, 1'b0);
    check("byp_reg", out_result, 32'd10);
    idle();
    drive(1'b1, OP_ADD, 32'd3, 32'd4, 5'd20, 5'd21, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    drive(1'b1, OP_ADD, 32'd0, 32'd0, 5'd0, 5'd21, 32'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    check("byp_x0", out_result, 32'd1);
    idle();

    // Flush drops the input and clears the bypass
    drive(1'b1, OP_ADD, 32'd40, 32'd2, 5'd20, 5'd21, 32'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    idle();
    drive(1'b1, OP_ADD, 32'd50, 32'd0, 5'd20, 5'd21, 32'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    drive(1'b1, OP_ADD, 32'd7, 32'd7, 5'd20, 5'd21, 32'd0, 1'b0, 5'd15, 1'b1, 1'b1);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_noload", out_result, 32'd50);
    drive(1'b1, OP_ADD, 32'd100, 32'd0, 5'd9, 5'd21, 32'd1, 1'b1, 5'd16, 1'b1, 1'b0);
    check("flush_nobyp", out_result, 32'd101);

    // Compare boundaries, wraparound and an undefined opcode
    drive(1'b1, OP_SLT, 32'hFFFFFFFF, 32'd1, 5'd30, 5'd31, 32'd0, 1'b0, 5'd17, 1'b1, 1'b0);
    check("slt", out_result, 32'd1);
    drive(1'b1, OP_SLTU, 32'hFFFFFFFF, 32'd1, 5'd30, 5'd31, 32'd0, 1'b0, 5'd18, 1'b1, 1'b0);
    check("sltu", out_result, 32'd0);
    drive(1'b1, OP_SUB, 32'd0, 32'd1, 5'd30, 5'd31, 32'd0, 1'b0, 5'd19, 1'b1, 1'b0);
    check("sub_wrap", out_result, 32'hFFFFFFFF);
    drive(1'b1, 4'hC, 32'd9, 32'd9, 5'd30, 5'd31, 32'd0, 1'b0, 5'd20, 1'b1, 1'b0);
    check("undef_res", out_result, 32'd0);
    check("undef_valid", 32'(out_valid), 32'd1);

    // Random traffic with small register indices to provoke forwarding
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 11)),
            $urandom(), $urandom(), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
